// File: rtl/gd_step_sequencer.sv
// ============================================================================
// gd_step_sequencer : gradient-descent loop controller for one signed 8.8 variable
// Rev 1.0
// ============================================================================
`default_nettype none

module gd_step_sequencer #(
   parameter int          MAX_ITER = 64,
   parameter int          LR_SHIFT = 3,
   parameter logic [15:0] EPS      = 16'h0010
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] x_init,
   output logic        grad_req,
   output logic [15:0] grad_x,
   input  logic        grad_valid,
   input  logic [15:0] grad_in,
   output logic        busy,
   output logic        done,
   output logic        converged,
   output logic [15:0] result_fx,
   output logic [7:0]  result_int,
   output logic [7:0]  iter_count
);

   localparam logic [7:0] MAX_ITER_W = 8'(MAX_ITER);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REQ    = 3'd1,
      S_WAIT   = 3'd2,
      S_UPDATE = 3'd3,
      S_SNAP   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t state, state_nx;

   logic signed [15:0] x;
   logic signed [15:0] grad;
   logic signed [15:0] step;
   logic signed [16:0] diff;
   logic [15:0]        x_sat;
   logic [15:0]        step_abs;
   logic [7:0]         iter_nx;
   logic [7:0]         snap_int;
   logic               small_step;
   logic               cap_hit;

   always_comb begin
      step = grad >>> LR_SHIFT;
      diff = $signed({x[15], x}) - $signed({step[15], step});
      if (diff > 17'sd32767)
         x_sat = 16'h7FFF;
      else if (diff < -17'sd32768)
         x_sat = 16'h8000;
      else
         x_sat = diff[15:0];
      // Negating the most negative step would overflow, so clamp its magnitude.
      if (step == 16'sh8000)
         step_abs = 16'h7FFF;
      else if (step[15])
         step_abs = 16'(-step);
      else
         step_abs = step;
      small_step = step_abs < EPS;
      iter_nx    = iter_count + 8'd1;
      cap_hit    = iter_nx == MAX_ITER_W;
      // Adding 0x7F before truncation makes exact halves round toward -inf.
      if (x > 16'sh7F00)
         snap_int = 8'h7F;
      else
         snap_int = 8'((x + 16'sh007F) >>> 8);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (start) state_nx = S_REQ;
         S_REQ:    state_nx = S_WAIT;
         S_WAIT:   if (grad_valid) state_nx = S_UPDATE;
         S_UPDATE: state_nx = (small_step || cap_hit) ? S_SNAP : S_REQ;
         S_SNAP:   state_nx = S_DONE;
         S_DONE:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x          <= '0;
         grad       <= '0;
         iter_count <= '0;
         converged  <= 1'b0;
         result_fx  <= '0;
         result_int <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  x          <= x_init;
                  iter_count <= '0;
                  converged  <= 1'b0;
               end
            end
            S_WAIT: begin
               if (grad_valid) grad <= grad_in;
            end
            S_UPDATE: begin
               x          <= x_sat;
               iter_count <= iter_nx;
               converged  <= small_step;
            end
            S_SNAP: begin
               result_fx  <= x;
               result_int <= snap_int;
            end
            default: ;
         endcase
      end
   end

   assign grad_req = (state == S_REQ);
   assign grad_x   = x;
   assign busy     = (state != S_IDLE);
   assign done     = (state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_gd_step_sequencer.sv
// ============================================================================
// tb_gd_step_sequencer : scoreboard bench with a reactive gradient responder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_gd_step_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] x_init;
   logic        grad_req;
   logic [15:0] grad_x;
   logic        grad_valid;
   logic [15:0] grad_in;
   logic        busy;
   logic        done;
   logic        converged;
   logic [15:0] result_fx;
   logic [7:0]  result_int;
   logic [7:0]  iter_count;

   gd_step_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .x_init     (x_init),
      .grad_req   (grad_req),
      .grad_x     (grad_x),
      .grad_valid (grad_valid),
      .grad_in    (grad_in),
      .busy       (busy),
      .done       (done),
      .converged  (converged),
      .result_fx  (result_fx),
      .result_int (result_int),
      .iter_count (iter_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] fx;
      logic [7:0]  ri;
      logic        conv;
      logic [7:0]  it;
   } exp_t;

   exp_t sb[$];

   int          n_cmp = 0;
   int          n_bad = 0;
   int          mode  = 0;
   logic [15:0] cval  = '0;
   int          delay = 0;
   bit          spur  = 1'b0;
   bit          resp_en = 1'b1;
   int          n_req = 0;
   int          stab_err = 0;
   logic [15:0] x_req2 = '0;

   logic [51:0] outs;
   assign outs = {grad_req, grad_x, busy, done, converged, result_fx, result_int, iter_count};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Gradient the external unit returns for a given x (16-bit wrap, like hardware).
   function automatic logic [15:0] grad_fn(input logic [15:0] xv);
      int d;
      case (mode)
         1:       return cval;
         2: begin
            d = 2 * (int'($signed(xv)) - 768);
            return d[15:0];
         end
         default: return 16'h0000;
      endcase
   endfunction

   function automatic exp_t model(input logic [15:0] xi);
      exp_t        e;
      int          x, g, st, a, it;
      bit          conv;
      logic [15:0] xv;
      x = int'($signed(xi));
      it = 0;
      conv = 1'b0;
      while (1) begin
         xv = x[15:0];
         g  = int'($signed(grad_fn(xv)));
         st = g >>> 3;
         x  = x - st;
         if (x > 32767)  x = 32767;
         if (x < -32768) x = -32768;
         it++;
         a = (st < 0) ? -st : st;
         if (a > 32767) a = 32767;
         if (a < 16) begin
            conv = 1'b1;
            break;
         end
         if (it == 64) break;
      end
      e.fx   = x[15:0];
      e.conv = conv;
      e.it   = it[7:0];
      if (x > 32512)
         e.ri = 8'h7F;
      else begin
         a    = (x + 127) >>> 8;
         e.ri = a[7:0];
      end
      return e;
   endfunction

   // Responds to each grad_req after 'delay' extra WAIT cycles; optionally
   // strobes grad_valid spuriously in IDLE and in the REQ cycle.
   initial begin
      logic [15:0] seen_x;
      grad_valid = 1'b0;
      grad_in    = '0;
      forever begin
         @(negedge clk);
         if (grad_req && resp_en) begin
            seen_x = grad_x;
            n_req++;
            if (n_req == 2) x_req2 = grad_x;
            grad_valid = spur;
            grad_in    = 16'h5A5A;
            for (int k = 0; k < delay; k++) begin
               @(negedge clk);
               grad_valid = 1'b0;
               if (grad_x !== seen_x) stab_err++;
            end
            @(negedge clk);
            if (grad_x !== seen_x) stab_err++;
            grad_valid = 1'b1;
            grad_in    = grad_fn(seen_x);
            @(negedge clk);
            grad_valid = 1'b0;
         end else begin
            grad_valid = spur && !busy;
            grad_in    = 16'hA5A5;
         end
      end
   end

   task automatic run(input logic [15:0] xi, input int m, input logic [15:0] cv,
                      input int d, input bit sp, input bit ab);
      exp_t e;
      int   cnt;
      mode  = m;
      cval  = cv;
      delay = d;
      spur  = sp;
      sb.push_back(model(xi));
      @(negedge clk);
      for (int k = 0; k < 50 && busy; k++) @(negedge clk);
      @(negedge clk);
      n_req    = 0;
      stab_err = 0;
      x_req2   = '0;
      x_init   = xi;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt   = 1;
      while (!done && cnt < 5000) begin
         if (ab && cnt == 2) begin
            start  = 1'b1;
            x_init = 16'h7000;
         end
         if (ab && cnt == 3) start = 1'b0;
         @(negedge clk);
         cnt++;
      end
      e = sb.pop_front();
      if (!done) begin
         chk("done_timeout", 0, 1);
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         return;
      end
      chk("result_fx", result_fx, e.fx);
      chk("result_int", result_int, e.ri);
      chk("converged", converged, e.conv);
      chk("iter_count", iter_count, e.it);
      chk("req_pulses", n_req, e.it);
      chk("gradx_stable", stab_err, 0);
      chk("latency", cnt, (3 + d) * e.it + 2);
      if (ab) begin
         start  = 1'b1;
         x_init = 16'h1234;
      end
      @(negedge clk);
      start = 1'b0;
      chk("done_len_busy_fall", {done, busy}, 2'b00);
      spur = 1'b0;
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      x_init = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_outs", outs, 0);
      end

      // Abort a run while it waits for a gradient.
      resp_en = 1'b0;
      x_init  = 16'h0100;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("wait_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_outs", outs, 0);
      @(negedge clk);
      rst_n   = 1'b1;
      resp_en = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", busy, 0);
      run(16'h0100, 0, 16'h0000, 0, 1'b0, 1'b0);

      run(16'h0280, 0, 16'h0000, 0, 1'b0, 1'b0);
      run(16'h0281, 0, 16'h0000, 0, 1'b0, 1'b0);
      run(16'hFE80, 0, 16'h0000, 0, 1'b0, 1'b0);

      run(16'h0000, 1, 16'h0100, 0, 1'b0, 1'b0);

      run(16'h7F80, 1, 16'h8000, 0, 1'b0, 1'b0);
      chk("sat_pin", x_req2, 16'h7FFF);

      run(16'h0000, 2, 16'h0000, 5, 1'b0, 1'b0);
      chk("quad_iters_le12", (iter_count <= 8'd12), 1);

      run(16'h0000, 2, 16'h0000, 2, 1'b1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/gd_step_sequencer.md
# gd_step_sequencer

Sequences an iterative gradient-descent search on a single signed 8.8 fixed-point variable. Each iteration requests a gradient from an external gradient unit over a request/valid handshake and applies a shift-scaled, saturating update. The loop stops on convergence or on an iteration cap. The final value is then snapped to the nearest signed 8-bit integer and presented with a one-cycle done pulse; the block is the top-level controller between the host start interface and the gradient datapath.

## Interface
- MAX_ITER, 64: iteration cap; legal range 1..255.
- LR_SHIFT, 3: learning rate = 2^-LR_SHIFT, applied as an arithmetic right shift of the gradient.
- EPS, 16'h0010: convergence threshold in 8.8 (1/16); compared against |step|.

- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a search; sampled only in IDLE.
- x_init  in  16  signed 8.8 starting point; latched when start is accepted.
- grad_req  out  1  one-cycle pulse requesting the gradient at grad_x.
- grad_x  out  16  signed 8.8 current x; stable from the REQ cycle until grad_valid is accepted.
- grad_valid  in  1  gradient-ready strobe; accepted only in WAIT.
- grad_in  in  16  signed 8.8 gradient; sampled with grad_valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- converged  out  1  1 means stopped on threshold, 0 means stopped on cap; held until next accepted start.
- result_fx  out  16  final signed 8.8 x; held.
- result_int  out  8  final x snapped to signed int8; held.
- iter_count  out  8  number of completed UPDATE cycles; held.

## Operation
- States: IDLE, REQ, WAIT, UPDATE, SNAP, DONE.
- IDLE to REQ on start. On entry: x ← x_init, iter_count ← 0, converged ← 0. start outside IDLE is ignored.
- REQ: grad_req=1 for exactly one cycle with grad_x=x; the next state is WAIT.
- WAIT: stays until grad_valid=1, then captures grad_in and goes to UPDATE. No timeout. grad_valid in any other state is ignored, including the REQ cycle.
- UPDATE:
  - step = grad >>> LR_SHIFT (sign-preserving).
  - diff = x − step, computed at 17 bits, then saturated to [16'h8000, 16'h7FFF] and written to x.
  - iter_count increments.
  - If |step| < EPS: converged ← 1 and go to SNAP.
  - Else if the new iter_count equals MAX_ITER: converged ← 0 and go to SNAP.
  - Otherwise go to REQ.
  - |step| of 16'h8000 saturates to 16'h7FFF.
- SNAP rule, registered into result_int, with result_fx ← x:
  - If x > 16'h7F00, result_int = 8'h7F.
  - Else result_int = (x + 16'h007F)[15:8].
  - Exact halves therefore round toward −∞ (2.5→2, −1.5→−2).
  - 16'h8000 yields −128.
- DONE: done=1 for one cycle, then IDLE. Outputs hold until the next accepted start.
- Reset (any state, including mid-WAIT): immediately returns to IDLE. All outputs are 0: grad_req, grad_x, busy, done, converged, result_fx, result_int, iter_count. A pending gradient response is dropped.

## Timing
- Cycle 0: start sampled in IDLE.
- Per iteration with grad_valid in the first WAIT cycle: REQ, WAIT, UPDATE = 3 cycles.
- With N iterations and zero gradient delay: SNAP in cycle 3N+1, done=1 in cycle 3N+2, busy falls in cycle 3N+3.
- A gradient delay of d extra cycles adds d per iteration.
- grad_req pulses exactly once per iteration. grad_x changes only in UPDATE.
- start in the cycle done=1 is ignored. It is accepted from the following IDLE cycle.

## Test plan
- Reset, then idle 5 cycles: every output 0 and grad_req never asserted. Assert rst_n low during WAIT, then release and start with x_init=16'h0100 and grad_in=0: returns to IDLE, a clean new run completes, result_int=1.
- Gradient model always 0 (instant grad_valid):
  - x_init=16'h0280 gives result_int=2.
  - x_init=16'h0281 gives result_int=3.
  - x_init=16'hFE80 gives result_int=−2 (8'hFE).
  - Each case: converged=1, iter_count=1, done in cycle 5.
- Constant grad_in=16'h0100, x_init=0, defaults: step=16'h0020 never converges. Expect iter_count=64, converged=0, result_fx=16'hF800, result_int=8'hF8, and exactly 64 grad_req pulses.
- Saturation: x_init=16'h7F80, grad_in=16'h8000. Expect x pinned at 16'h7FFF after the first UPDATE, result_int=8'h7F, converged=0, iter_count=64.
- Model grad=2·(x−3.0), x_init=0, grad_valid delayed 5 cycles:
  - Expect converged=1, result_int=3, iter_count≤12.
  - One grad_req per iteration.
  - grad_x stable throughout each WAIT.
- Protocol abuse:
  - start pulsed while busy: no effect.
  - Spurious grad_valid in IDLE or in the REQ cycle: ignored, and results match a clean run.
  - start in the done cycle: ignored.
